alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU for the execute stage, successor to the single-cycle combinational ALU. Single-cycle ops (add, sub, and, or, slt) complete in one clock. Unsigned multiply and divide run as iterative shift-add / restoring-divide engines over WIDTH cycles, producing a full double-width result. A start/busy/done handshake lets the hazard unit stall the pipeline while an iterative op is in flight.

---
 rtl/alu_multicycle.sv | 171 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU. Single-cycle ops are registered on the
// start edge. Unsigned multiply and divide iterate once per clock for WIDTH
// clocks and produce a double-width result.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             Zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             divz_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // wk_hi: accumulator (mul) / partial remainder (div)
    // wk_lo: multiplier shifting out (mul) / dividend-to-quotient (div)
    // opnd:  multiplicand (mul) / divisor (div)
    logic [WIDTH-1:0] wk_hi_q, wk_hi_d;
    logic [WIDTH-1:0] wk_lo_q, wk_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

    // Result of the single-cycle ops from the live inputs.
    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_AND:  single_res = data1_i & data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: single_res = '0;
        endcase
    end

    // One shift-add step and one restoring-divide step on the working registers.
    always_comb begin
        mul_sum    = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nx  = mul_sum[WIDTH:1];
        mul_lo_nx  = {mul_sum[0], wk_lo_q[WIDTH-1:1]};
        div_trial  = {wk_hi_q, wk_lo_q[WIDTH-1]} - {1'b0, opnd_q};
        // A divisor of zero never borrows, so the quotient fills with ones
        // and the dividend shifts whole into the remainder.
        if (div_trial[WIDTH]) begin
            div_rem_nx = {wk_hi_q[WIDTH-2:0], wk_lo_q[WIDTH-1]};
            div_quo_nx = {wk_lo_q[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_nx = div_trial[WIDTH-1:0];
            div_quo_nx = {wk_lo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and result commit; everything holds unless changed below.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wk_hi_d = wk_hi_q;
        wk_lo_d = wk_lo_q;
        opnd_d  = opnd_q;
        data_d  = data_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ALUCtrl_i == OP_MUL || ALUCtrl_i == OP_DIV) begin
                        state_d = (ALUCtrl_i == OP_MUL) ? S_MUL : S_DIV;
                        cnt_d   = '0;
                        wk_hi_d = '0;
                        wk_lo_d = data1_i;
                        opnd_d  = data2_i;
                    end else begin
                        data_d = single_res;
                        hi_d   = '0;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                cnt_d   = cnt_q + 1'b1;
                wk_hi_d = mul_hi_nx;
                wk_lo_d = mul_lo_nx;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    data_d  = mul_lo_nx;
                    hi_d    = mul_hi_nx;
                    done_d  = 1'b1;
                end
            end
            S_DIV: begin
                cnt_d   = cnt_q + 1'b1;
                wk_hi_d = div_rem_nx;
                wk_lo_d = div_quo_nx;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    data_d  = div_quo_nx;
                    hi_d    = div_rem_nx;
                    done_d  = 1'b1;
                    divz_d  = (opnd_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = done_d ? (data_d == '0) : zero_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wk_hi_q <= '0;
            wk_lo_q <= '0;
            opnd_q  <= '0;
            data_q  <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wk_hi_q <= wk_hi_d;
            wk_lo_q <= wk_lo_d;
            opnd_q  <= opnd_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign data_o = data_q;
    assign hi_o   = hi_q;
    assign Zero_o = zero_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign divz_o = divz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and random checks of alu_multicycle against an arithmetic model.
module tb_alu_multicycle;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  d1, d2;
    logic [3:0]    ctrl;
    logic [W-1:0]  data, hi;
    logic          zero, busy, done, divz;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  last_lo;
    logic [W-1:0]  last_hi;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data1_i(d1), .data2_i(d2),
        .ALUCtrl_i(ctrl), .data_o(data), .hi_o(hi), .Zero_o(zero),
        .busy_o(busy), .done_o(done), .divz_o(divz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the arithmetic definition of each op.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] h, output logic dz);
        logic [63:0] p;
        lo = '0; h = '0; dz = 1'b0;
        case (op)
            4'b0010: lo = a + b;
            4'b0110: lo = a - b;
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b0111: lo = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0011: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; h = p[63:32]; end
            4'b0100: begin
                if (b == 0) begin lo = '1; h = a; dz = 1'b1; end
                else begin lo = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Issue one op at the next negedge and check result, flags and latency.
    // scr scrambles every input while the iterative op is busy.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit scr);
        logic [W-1:0] elo, ehi;
        logic         edz;
        int           lat;
        model(op, a, b, elo, ehi, edz);
        @(negedge clk);
        start = 1'b1; ctrl = op; d1 = a; d2 = b;
        @(posedge clk); #1;
        lat = 0;
        if (op == 4'b0011 || op == 4'b0100) begin
            chk({tag, ".busy0"}, {63'b0, busy}, 64'd1);
            chk({tag, ".done0"}, {63'b0, done}, 64'd0);
            while (!done && lat < 40) begin
                @(negedge clk);
                if (scr) begin
                    start = 1'($urandom); d1 = $urandom; d2 = $urandom; ctrl = 4'($urandom);
                end else start = 1'b0;
                @(posedge clk); #1;
                lat++;
                if (!done) chk({tag, ".busy"}, {63'b0, busy}, 64'd1);
            end
            chk({tag, ".lat"}, 64'(lat), 64'(W));
        end
        chk({tag, ".done"}, {63'b0, done}, 64'd1);
        chk({tag, ".busyd"}, {63'b0, busy}, 64'd0);
        chk({tag, ".lo"}, {32'b0, data}, {32'b0, elo});
        chk({tag, ".hi"}, {32'b0, hi}, {32'b0, ehi});
        chk({tag, ".zero"}, {63'b0, zero}, {63'b0, (elo == 0)});
        chk({tag, ".divz"}, {63'b0, divz}, {63'b0, edz});
        last_lo = elo;
        last_hi = ehi;
        start = 1'b0;
    endtask

    // One idle cycle: done must fall and results must hold.
    task automatic idle_chk(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done"}, {63'b0, done}, 64'd0);
        chk({tag, ".divz"}, {63'b0, divz}, 64'd0);
        chk({tag, ".hold"}, {data, hi}, {last_lo, last_hi});
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".data"}, {32'b0, data}, 64'd0);
        chk({tag, ".hi"}, {32'b0, hi}, 64'd0);
        chk({tag, ".flags"}, {60'b0, zero, busy, done, divz}, 64'b1000);
    endtask

    initial begin
        logic [3:0] ops [8];
        int         seen_done;
        ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0011, 4'b0100, 4'b1111};
        rst = 1'b1; start = 1'b0; d1 = '0; d2 = '0; ctrl = '0;
        repeat (2) @(posedge clk);
        #1 reset_chk("reset");
        @(negedge clk); rst = 1'b0;

        run_op("add7p5", 4'b0010, 7, 5, 0);
        run_op("sub5m5", 4'b0110, 5, 5, 0);
        run_op("addwrap", 4'b0010, 32'hFFFF_FFFF, 1, 0);
        run_op("sltneg", 4'b0111, 32'hFFFF_FFFF, 1, 0);
        run_op("sltpos", 4'b0111, 1, 32'hFFFF_FFFF, 0);
        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_0100, 0);
        run_op("undef", 4'b1111, 32'h1234, 32'h5678, 0);
        idle_chk("idle1");
        run_op("mulmax", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle_chk("idle2");
        run_op("mul6x7", 4'b0011, 6, 7, 0);
        run_op("div100_7", 4'b0100, 100, 7, 0);
        run_op("div9_0", 4'b0100, 9, 0, 0);
        idle_chk("idle3");
        // Scrambled inputs during a mul, then an add in its done cycle.
        run_op("mulscr", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op("addindone", 4'b0010, 40, 2, 0);
        run_op("divscr", 4'b0100, 32'hDEAD_BEEF, 32'h0000_1234, 1);
        idle_chk("idle4");

        // Reset in cycle 10 of a divide, with start held high on the reset edge.
        @(negedge clk);
        start = 1'b1; ctrl = 4'b0100; d1 = 1000; d2 = 3;
        seen_done = 0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk); rst = 1'b1; start = 1'b1; ctrl = 4'b0010; d1 = 3; d2 = 4;
        @(posedge clk); #1;
        reset_chk("midrst");
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        chk("midrst.nodone", 64'(seen_done), 64'd0);
        last_lo = 0; last_hi = 0;
        run_op("add1p1", 4'b0010, 1, 1, 0);

        // Random ops, including operand corner values.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            a = $urandom; b = $urandom;
            if (i % 6 == 1) b = 0;
            if (i % 6 == 2) b = $urandom_range(1, 255);
            if (i % 6 == 3) a = 32'hFFFF_FFFF;
            run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 7)], a, b, bit'($urandom));
        end
        idle_chk("idle5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
